cache_line_store: RTL and testbench
===================================

Name: cache_line_store

Overview:
- Storage arrays for the direct-mapped, one-word-per-line cache: a tag array and a data array, both indexed by the same line index.
- Sits under the cache controller. The controller drives index, write enables and write data; this block returns the addressed tag entry and data word.
- Holds no policy: no hit/miss decision and no replacement logic.

Parameters:
- ADDR_W, 32, CPU byte-address width.
- OFFSET_W, 2, byte-offset bits. Lines are word aligned.
- IDX_W, 5, index width. The array depth is LINES = 2**IDX_W (32).
- DATA_W, 32, data word width.
- TAG_W (localparam), ADDR_W-IDX_W-OFFSET_W (25), stored tag width.
- TAG_MEM_W (localparam), TAG_W+2 (27), tag entry width.
- VALID_BIT (localparam), TAG_MEM_W-1.
- DIRTY_BIT (localparam), TAG_MEM_W-2.

Ports:
- iCLK  in  1  Single clock. Every state change happens on the rising edge.
- iRST  in  1  Reset, synchronous and active-high.
- idx  in  IDX_W  Line index, shared by both arrays for read and write.
- tag_we  in  1  Tag-array write enable.
- tag_block_in  in  TAG_MEM_W  Tag entry to write, formatted {valid, dirty, tag[TAG_W-1:0]}.
- tag_block_out  out  TAG_MEM_W  Tag entry at idx.
- data_we  in  1  Data-array write enable.
- data_block_in  in  DATA_W  Data word to write.
- data_block_out  out  DATA_W  Data word at idx.

Behaviour:
- Reads are asynchronous (combinational). tag_block_out = tag_array[idx] and data_block_out = data_array[idx], with zero-cycle latency after an idx change.
- Writes are synchronous. At the iCLK rising edge, tag_we=1 writes tag_block_in into tag_array[idx], and data_we=1 writes data_block_in into data_array[idx].
- The two enables are independent. Both may assert in the same cycle. A write of either array never disturbs the other.
- Same-index read during a write: with the feature macro undefined, the outputs show the old contents for the whole write cycle and the new contents from the cycle after the edge.
- Reset (iRST=1 at an edge): every tag entry is cleared to 0 (valid=0, dirty=0, tag=0) and every data word is cleared to 0. This takes a single edge (flop-based arrays, no reset sweep).
- Reset overrides writes: if iRST and a write enable are both high at the same edge, the clear wins.
- Reset mid-operation discards all contents. After reset every line reads as invalid.
- Tag entry bit layout is fixed: bit VALID_BIT = valid, bit DIRTY_BIT = dirty, bits [TAG_W-1:0] = tag. The block stores these bits verbatim and never interprets them.
- Outputs are never X after the first reset edge.
- There is no stall and no handshake; every access completes in the cycle it is presented.
- Out-of-range idx is impossible, since the depth is exactly 2**IDX_W.

Optional Feature:
- Macro CACHE_LINE_STORE_WR_FWD_EN.
- When defined: during a cycle where tag_we=1, tag_block_out returns tag_block_in combinationally. Likewise data_we=1 makes data_block_out return data_block_in. This is write-through read forwarding, so the controller sees the new line in the same cycle.
- When undefined: outputs always show the stored array contents (old data during a write).

Decomposition:
- Shared package cache_pkg holds:
  - default widths ADDR_W, OFFSET_W, IDX_W, DATA_W;
  - derived TAG_W, TAG_MEM_W;
  - bit positions VALID_BIT, DIRTY_BIT;
  - the tag-entry packed typedef {valid, dirty, tag}.
- One generic sub-module, cache_ram_1rw. It is a parameterised (WIDTH, DEPTH_LOG2) async-read, sync-write, sync-clear array with optional forwarding.
- It is instantiated twice: once for tags (TAG_MEM_W) and once for data (DATA_W).

Test Plan:
- Reset then read: assert iRST for 1 cycle, then sweep idx 0..31 -> tag_block_out=0 and data_block_out=0 at every index.
- Allocate line: idx=1, tag_we=1, tag_block_in={1,0,25'h0000001}, data_we=1, data_block_in=32'hDEADBEEF for one edge -> following cycle, idx=1 reads tag 27'h4000001 and data DEADBEEF. idx=0 and idx=2 still read 0.
- Independent enables: idx=5, data_we=1 only with 32'h12345678 -> data at idx 5 updates and tag at idx 5 stays 0. Then tag_we=1 only with {1,1,25'h3} -> tag 27'h6000003 and data unchanged.
- Overwrite/alias: write data 32'hAAAA0000 at idx=1, then 32'h5555FFFF at idx=1 -> reads 5555FFFF. Index 31 writes do not wrap onto index 0.
- Reset vs write: iRST=1 together with tag_we=1 and data_we=1 at idx=3 -> idx 3 reads 0. Reset mid-sequence after the earlier writes -> all lines read 0.
- Same-cycle read during write at idx=7 with data 32'hCAFEF00D:
  - macro undefined: old value (0) during the write cycle, CAFEF00D after the edge;
  - with CACHE_LINE_STORE_WR_FWD_EN: CAFEF00D in the write cycle itself.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, tag-entry layout and helpers for the cache line store
package cache_pkg;

  // Default geometry of the direct-mapped, one-word-per-line cache
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 2;
  localparam int IDX_W    = 5;
  localparam int DATA_W   = 32;

  // Derived tag widths: stored tag plus valid and dirty flags
  localparam int TAG_W     = ADDR_W - IDX_W - OFFSET_W;
  localparam int TAG_MEM_W = TAG_W + 2;

  // Fixed bit positions of the flags inside a tag entry
  localparam int VALID_BIT = TAG_MEM_W - 1;
  localparam int DIRTY_BIT = TAG_MEM_W - 2;

  // Tag entry as seen by the controller: {valid, dirty, tag}
  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  // Build a raw tag entry from its fields using the fixed bit positions
  function automatic logic [TAG_MEM_W-1:0] pack_tag_entry(
    input logic             valid,
    input logic             dirty,
    input logic [TAG_W-1:0] tag
  );
    logic [TAG_MEM_W-1:0] e;
    e            = '0;
    e[VALID_BIT] = valid;
    e[DIRTY_BIT] = dirty;
    e[TAG_W-1:0] = tag;
    return e;
  endfunction

endpackage

// File: rtl/cache_ram_1rw.sv
// rtl/cache_ram_1rw.sv - flop array with async read, sync write, one-edge clear and optional forwarding
module cache_ram_1rw #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 5,
  parameter bit FWD_EN     = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [WIDTH-1:0]      i_wdata,
  output logic [WIDTH-1:0]      o_rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] w_stored;

  // Clear every entry in one edge; clear takes priority over a write
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Depth is exactly 2**DEPTH_LOG2, so every address selects a real entry
  assign w_stored = r_mem[i_addr];

  generate
    if (FWD_EN) begin : g_fwd
      // Write-through: the entry being written is visible in its own cycle
      assign o_rdata = i_we ? i_wdata : w_stored;
    end else begin : g_nofwd
      // Stored contents only; a write shows up from the cycle after the edge
      assign o_rdata = w_stored;
    end
  endgenerate

endmodule

// File: rtl/cache_line_store.sv
// rtl/cache_line_store.sv - tag and data arrays of the direct-mapped cache; CACHE_LINE_STORE_WR_FWD_EN enables write forwarding
module cache_line_store #(
  parameter int ADDR_W   = cache_pkg::ADDR_W,
  parameter int OFFSET_W = cache_pkg::OFFSET_W,
  parameter int IDX_W    = cache_pkg::IDX_W,
  parameter int DATA_W   = cache_pkg::DATA_W
) (
  input  logic                                  iCLK,
  input  logic                                  iRST,
  input  logic [IDX_W-1:0]                      idx,
  input  logic                                  tag_we,
  input  logic [ADDR_W-IDX_W-OFFSET_W+2-1:0]    tag_block_in,
  output logic [ADDR_W-IDX_W-OFFSET_W+2-1:0]    tag_block_out,
  input  logic                                  data_we,
  input  logic [DATA_W-1:0]                     data_block_in,
  output logic [DATA_W-1:0]                     data_block_out
);

  import cache_pkg::*;

  localparam int TAG_W     = ADDR_W - IDX_W - OFFSET_W;
  localparam int TAG_MEM_W = TAG_W + 2;
  localparam int VALID_BIT = TAG_MEM_W - 1;
  localparam int DIRTY_BIT = TAG_MEM_W - 2;

`ifdef CACHE_LINE_STORE_WR_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic [TAG_MEM_W-1:0] w_tag_wr;

  // Tag fields are routed verbatim into their fixed slots; nothing is interpreted here
  assign w_tag_wr = {tag_block_in[VALID_BIT], tag_block_in[DIRTY_BIT], tag_block_in[TAG_W-1:0]};

  cache_ram_1rw #(
    .WIDTH      (TAG_MEM_W),
    .DEPTH_LOG2 (IDX_W),
    .FWD_EN     (FWD_EN)
  ) u_tag_ram (
    .i_clk   (iCLK),
    .i_rst   (iRST),
    .i_we    (tag_we),
    .i_addr  (idx),
    .i_wdata (w_tag_wr),
    .o_rdata (tag_block_out)
  );

  cache_ram_1rw #(
    .WIDTH      (DATA_W),
    .DEPTH_LOG2 (IDX_W),
    .FWD_EN     (FWD_EN)
  ) u_data_ram (
    .i_clk   (iCLK),
    .i_rst   (iRST),
    .i_we    (data_we),
    .i_addr  (idx),
    .i_wdata (data_block_in),
    .o_rdata (data_block_out)
  );

endmodule

// File: tb/tb_cache_line_store.sv
// tb/tb_cache_line_store.sv - directed scoreboard bench for cache_line_store
module tb_cache_line_store;
  import cache_pkg::*;

  localparam int LINES = 1 << IDX_W;
`ifdef CACHE_LINE_STORE_WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                 iCLK = 1'b0;
  logic                 iRST = 1'b1;
  logic [IDX_W-1:0]     idx = '0;
  logic                 tag_we = 1'b0;
  logic [TAG_MEM_W-1:0] tag_block_in = '0;
  logic [TAG_MEM_W-1:0] tag_block_out;
  logic                 data_we = 1'b0;
  logic [DATA_W-1:0]    data_block_in = '0;
  logic [DATA_W-1:0]    data_block_out;

  always #5 iCLK = ~iCLK;

  cache_line_store dut (
    .iCLK           (iCLK),
    .iRST           (iRST),
    .idx            (idx),
    .tag_we         (tag_we),
    .tag_block_in   (tag_block_in),
    .tag_block_out  (tag_block_out),
    .data_we        (data_we),
    .data_block_in  (data_block_in),
    .data_block_out (data_block_out)
  );

  typedef struct packed {
    logic [TAG_MEM_W-1:0] tag;
    logic [DATA_W-1:0]    data;
  } exp_t;

  logic [TAG_MEM_W-1:0] m_tag  [LINES];
  logic [DATA_W-1:0]    m_data [LINES];
  exp_t                 exp_q[$];
  int                   n_tests = 0;
  int                   n_fail  = 0;

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) begin
      m_tag[i]  = '0;
      m_data[i] = '0;
    end
  endtask

  task automatic compare_out(input string name);
    exp_t e;
    e = exp_q.pop_front();
    n_tests++;
    assert (tag_block_out === e.tag)
      else begin
        n_fail++;
        $error("FAIL %s tag observed %h expected %h", name, tag_block_out, e.tag);
      end
    n_tests++;
    assert (data_block_out === e.data)
      else begin
        n_fail++;
        $error("FAIL %s data observed %h expected %h", name, data_block_out, e.data);
      end
  endtask

  task automatic check_line(input int i);
    idx = i[IDX_W-1:0];
    exp_q.push_back(exp_t'({m_tag[i], m_data[i]}));
    #2;
    compare_out($sformatf("line%0d", i));
  endtask

  task automatic check_const(input int i, input logic [TAG_MEM_W-1:0] t,
                             input logic [DATA_W-1:0] d, input string name);
    idx = i[IDX_W-1:0];
    exp_q.push_back(exp_t'({t, d}));
    #2;
    compare_out(name);
  endtask

  task automatic sweep(input string name);
    for (int i = 0; i < LINES; i++) begin
      idx = i[IDX_W-1:0];
      exp_q.push_back(exp_t'({m_tag[i], m_data[i]}));
      #2;
      compare_out($sformatf("%s_idx%0d", name, i));
    end
  endtask

  task automatic write_line(input int i, input logic twe, input logic [TAG_MEM_W-1:0] tin,
                            input logic dwe, input logic [DATA_W-1:0] din);
    @(posedge iCLK);
    #1;
    idx           = i[IDX_W-1:0];
    tag_we        = twe;
    tag_block_in  = tin;
    data_we       = dwe;
    data_block_in = din;
    exp_q.push_back(exp_t'({(FWD && twe) ? tin : m_tag[i], (FWD && dwe) ? din : m_data[i]}));
    #2;
    compare_out($sformatf("wr_cycle_idx%0d", i));
    @(posedge iCLK);
    #1;
    if (twe) m_tag[i] = tin;
    if (dwe) m_data[i] = din;
    tag_we  = 1'b0;
    data_we = 1'b0;
  endtask

  task automatic reset_cycle(input int i, input logic twe, input logic [TAG_MEM_W-1:0] tin,
                             input logic dwe, input logic [DATA_W-1:0] din);
    @(posedge iCLK);
    #1;
    iRST          = 1'b1;
    idx           = i[IDX_W-1:0];
    tag_we        = twe;
    tag_block_in  = tin;
    data_we       = dwe;
    data_block_in = din;
    @(posedge iCLK);
    #1;
    iRST    = 1'b0;
    tag_we  = 1'b0;
    data_we = 1'b0;
    model_clear();
  endtask

  initial begin
    model_clear();

    // Reset then read every line
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    sweep("reset");

    // Allocate line 1 with both enables
    write_line(1, 1'b1, pack_tag_entry(1'b1, 1'b0, 25'h0000001), 1'b1, 32'hDEADBEEF);
    check_const(1, 27'h4000001, 32'hDEADBEEF, "alloc_idx1");
    check_line(0);
    check_line(2);

    // Independent enables at line 5
    write_line(5, 1'b0, pack_tag_entry(1'b1, 1'b1, 25'h1FFFFFF), 1'b1, 32'h12345678);
    check_const(5, 27'h0, 32'h12345678, "data_only_idx5");
    write_line(5, 1'b1, pack_tag_entry(1'b1, 1'b1, 25'h3), 1'b0, 32'hFFFFFFFF);
    check_const(5, 27'h6000003, 32'h12345678, "tag_only_idx5");

    // Overwrite line 1 twice
    write_line(1, 1'b0, '0, 1'b1, 32'hAAAA0000);
    check_line(1);
    write_line(1, 1'b0, '0, 1'b1, 32'h5555FFFF);
    check_const(1, 27'h4000001, 32'h5555FFFF, "overwrite_idx1");

    // Top line must not alias onto line 0
    write_line(31, 1'b1, pack_tag_entry(1'b1, 1'b0, 25'h1FFFFFF), 1'b1, 32'hFFFF0031);
    check_line(31);
    check_const(0, 27'h0, 32'h0, "no_wrap_idx0");

    // Reset wins over simultaneous writes, and wipes all earlier writes
    write_line(3, 1'b1, pack_tag_entry(1'b1, 1'b1, 25'h0ABCDEF), 1'b1, 32'h33333333);
    check_line(3);
    reset_cycle(3, 1'b1, pack_tag_entry(1'b1, 1'b1, 25'h1234567), 1'b1, 32'h77777777);
    check_const(3, 27'h0, 32'h0, "rst_vs_wr_idx3");
    sweep("midreset");

    // Same-index read during a write at line 7
    write_line(7, 1'b0, '0, 1'b1, 32'hCAFEF00D);
    check_const(7, 27'h0, 32'hCAFEF00D, "after_wr_idx7");
    write_line(7, 1'b1, pack_tag_entry(1'b1, 1'b0, 25'h0000077), 1'b1, 32'h0BADC0DE);
    check_line(7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
